// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and bit-timing helper for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// sync_2ff: two-flop synchroniser with a configurable reset value
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receive path with valid/ready output and sticky overrun/framing flags
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around every sample point.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    input  logic       error_clear
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(SAMPLE_TIME - 1);

    state_t state, state_n;
    logic rx_s, tick, decide, sample;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic valid_n, fe_n, ov_n;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (.clk(clk), .rst(rst), .d(serial_in), .q(rx_s));

    assign tick = (state == START && cnt == CNT_MID) || ((state == DATA || state == STOP) && cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    // Counter phase is unchanged; only the decision waits one cycle for the mid+1 sample.
    logic [1:0] hist;
    logic tick_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            hist   <= 2'b11;
            tick_d <= 1'b0;
        end else begin
            hist   <= {hist[0], rx_s};
            tick_d <= tick;
        end
    end
    assign decide = tick_d;
    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign decide = tick;
    assign sample = rx_s;
`endif

    assign cnt_n = (tick || (state == IDLE && !rx_s)) ? '0 : (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            shreg          <= shreg_n;
            data_out       <= data_n;
            data_out_valid <= valid_n;
            framing_error  <= fe_n;
            overrun        <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_out;
        valid_n = data_out_valid & ~data_out_ready;
        fe_n    = framing_error & ~error_clear;
        ov_n    = overrun & ~error_clear;
        case (state)
            WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
            IDLE:      state_n = rx_s ? IDLE : START;
            START: if (decide) begin
                state_n = sample ? IDLE : DATA;
                idx_n   = '0;
            end
            DATA: if (decide) begin
                shreg_n[idx] = sample;
                idx_n        = idx + 3'd1;
                state_n      = (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (decide) begin
                if (!sample) begin
                    fe_n    = 1'b1;
                    state_n = WAIT_IDLE;
                end else begin
                    state_n = IDLE;
                    if (!data_out_valid || data_out_ready) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        ov_n = 1'b1;
                    end
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 50 MHz / 8680 ns bits, checked with immediate assertions
module tb_uart_receiver;
    localparam int BIT = 8680;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic [7:0] data_out;
    logic data_out_valid;
    logic data_out_ready = 1'b1;
    logic framing_error;
    logic overrun;
    logic error_clear = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] rxq[$];
    longint rxt[$];
    longint t_fall;
    longint lat;
    int base;

    uart_receiver dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .framing_error(framing_error), .overrun(overrun), .error_clear(error_clear)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) begin
            rxq.push_back(data_out);
            rxt.push_back($time);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        t_fall = $time;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            #BIT;
        end
        serial_in = stop;
        #BIT;
        serial_in = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #2;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("reset_data", data_out, 8'h00);
        check("reset_valid", data_out_valid, 1'b0);
        check("reset_fe", framing_error, 1'b0);
        check("reset_ov", overrun, 1'b0);
        #(2 * BIT);

        send_byte(8'h61, 1'b1);
        #(2 * BIT);
        check("s1_count", rxq.size(), 1);
        check("s1_data", rxq[0], 8'h61);
        lat = (rxt[0] - t_fall + 10) / 20;
        check("s1_latency", (lat >= 4125 && lat <= 4127), 1'b1);
        check("s1_fe", framing_error, 1'b0);
        check("s1_ov", overrun, 1'b0);

        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h63, 1'b1);
        send_byte(8'h64, 1'b1);
        send_byte(8'h20, 1'b1);
        #(2 * BIT);
        check("s2_count", rxq.size(), 6);
        check("s2_b0", rxq[1], 8'h61);
        check("s2_b1", rxq[2], 8'h62);
        check("s2_b2", rxq[3], 8'h63);
        check("s2_b3", rxq[4], 8'h64);
        check("s2_b4", rxq[5], 8'h20);
        check("s2_fe", framing_error, 1'b0);
        check("s2_ov", overrun, 1'b0);

        data_out_ready = 1'b0;
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        #(2 * BIT);
        check("s3_valid_held", data_out_valid, 1'b1);
        check("s3_data_held", data_out, 8'h41);
        check("s3_ov", overrun, 1'b1);
        check("s3_fe", framing_error, 1'b0);
        data_out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("s3_valid_drop", data_out_valid, 1'b0);
        check("s3_count", rxq.size(), 7);
        check("s3_consumed", rxq[6], 8'h41);
        error_clear = 1'b1;
        @(posedge clk);
        #2;
        error_clear = 1'b0;
        check("s3_ov_clear", overrun, 1'b0);

        send_byte(8'h55, 1'b0);
        #(2 * BIT);
        check("s4_fe", framing_error, 1'b1);
        check("s4_no_byte", rxq.size(), 7);
        check("s4_valid", data_out_valid, 1'b0);
        send_byte(8'h5A, 1'b1);
        #(2 * BIT);
        check("s4_count", rxq.size(), 8);
        check("s4_data", rxq[7], 8'h5A);
        check("s4_fe_sticky", framing_error, 1'b1);
        error_clear = 1'b1;
        @(posedge clk);
        #2;
        error_clear = 1'b0;
        check("s4_fe_clear", framing_error, 1'b0);

        serial_in = 1'b0;
        #2000;
        serial_in = 1'b1;
        #(2 * BIT);
        check("s5_glitch", rxq.size(), 8);
        send_byte(8'h0D, 1'b1);
        #(2 * BIT);
        check("s5_count", rxq.size(), 9);
        check("s5_data", rxq[8], 8'h0D);

        base = rxq.size();
        serial_in = 1'b0;
        #BIT;
        serial_in = 1'b1;
        #BIT;
        serial_in = 1'b0;
        #BIT;
        serial_in = 1'b1;
        #BIT;
        serial_in = 1'b0;
        #(BIT / 2);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("s6_rst_data", data_out, 8'h00);
        check("s6_rst_valid", data_out_valid, 1'b0);
        #400;
        serial_in = 1'b1;
        #(12 * BIT);
        check("s6_no_byte", rxq.size(), base);
        send_byte(8'h3E, 1'b1);
        #(2 * BIT);
        check("s6_count", rxq.size(), base + 1);
        check("s6_data", rxq[base], 8'h3E);
        check("s6_fe", framing_error, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
